// File: rtl/pixel_stream_tx_pkg.sv
// Shared definitions for the pixel transmitter and the processing stage it feeds:
// controller state encoding, default image geometry and small decode helpers.
package pixel_stream_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_SEND = 2'd2,
      ST_TAIL = 2'd3
   } tx_state_t;

   localparam int DEF_IMG_WIDTH   = 32;
   localparam int DEF_IMG_HEIGHT  = 32;
   localparam int DEF_FIFO_DEPTH  = 64;
   localparam int DEF_TAIL_CYCLES = 4;
   localparam int PIX_W           = 8;

   // The downstream stage is enabled whenever the controller has left IDLE.
   function automatic logic stage_enabled(input tx_state_t s);
      return (s != ST_IDLE);
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with a first-word-fall-through head, full/empty flags,
// a synchronous flush and a drop indication for pushes refused while full.
module pixel_fifo #(
   parameter int DEPTH = 64,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          i_flush,
   input  logic          i_wr_en,
   input  logic [DW-1:0] i_wr_data,
   input  logic          i_rd_en,
   output logic [DW-1:0] o_rd_data,
   output logic          o_full,
   output logic          o_empty,
   output logic          o_drop
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic [DW-1:0] r_mem [DEPTH];
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;

   // Flags and handshakes; a pop frees a slot in the same cycle so a push at full still lands.
   always_comb begin
      w_empty   = (r_wr_ptr == r_rd_ptr);
      w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
      w_pop     = i_rd_en && !w_empty;
      w_push    = i_wr_en && (!w_full || w_pop);
      o_drop    = i_wr_en && !w_push;
      o_full    = w_full;
      o_empty   = w_empty;
      o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
   end

   // Read and write pointers; flush empties the FIFO and discards a same-cycle push.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
      end
   end

   // Storage array.
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
      end
   end

endmodule

// File: rtl/pixel_stream_tx.sv
// Frame-oriented pixel transmitter: buffers host pixels in a FIFO and streams one
// frame per go request over a valid/ready link, enabling the processing stage around it.
module pixel_stream_tx
   import pixel_stream_tx_pkg::*;
#(
   parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int TAIL_CYCLES = DEF_TAIL_CYCLES
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          wr_en,
   input  logic [7:0]                    wr_data,
   output logic                          wr_full,
   output logic                          overflow,
   input  logic                          go,
   input  logic                          abort,
   output logic                          busy,
   output logic                          frame_done,
   output logic [7:0]                    pixel_out,
   output logic                          VALID_OUT,
   input  logic                          READY_IN,
   output logic                          start,
   output logic [$clog2(IMG_WIDTH)-1:0]  col,
   output logic [$clog2(IMG_HEIGHT)-1:0] row
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int TW = $clog2(TAIL_CYCLES + 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
   localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_CYCLES - 1);

   tx_state_t     r_state;
   tx_state_t     w_next_state;
   logic          r_valid;
   logic [7:0]    r_pix;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [TW-1:0] r_tail_cnt;
   logic          r_start;
   logic          r_busy;
   logic          r_frame_done;
   logic          r_overflow;

   logic          w_xfer;
   logic          w_at_last;
   logic          w_last_xfer;
   logic          w_load_window;
   logic          w_pop;
   logic          w_fifo_empty;
   logic          w_fifo_full;
   logic          w_fifo_drop;
   logic [7:0]    w_fifo_head;
   logic          w_start_d;
   logic          w_busy_d;
   logic          w_frame_done_d;

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (8)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .i_flush   (abort),
      .i_wr_en   (wr_en),
      .i_wr_data (wr_data),
      .i_rd_en   (w_pop),
      .o_rd_data (w_fifo_head),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty),
      .o_drop    (w_fifo_drop)
   );

   // Handshake decode. Loading already happens on the ARM->SEND edge so the first beat
   // is valid one cycle after start; once the last beat of the frame sits in the output
   // register no further pixel is taken from the FIFO.
   always_comb begin
      w_xfer        = r_valid && READY_IN;
      w_at_last     = (r_col == COL_LAST) && (r_row == ROW_LAST);
      w_last_xfer   = (r_state == ST_SEND) && w_xfer && w_at_last;
      w_load_window = (r_state == ST_ARM) ||
                      ((r_state == ST_SEND) && !(r_valid && w_at_last));
      w_pop         = !abort && w_load_window && !w_fifo_empty && (!r_valid || READY_IN);
   end

   // State register plus the registered control outputs derived from the next state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= ST_IDLE;
         r_start      <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_start      <= w_start_d;
         r_busy       <= w_busy_d;
         r_frame_done <= w_frame_done_d;
      end
   end

   // Next-state logic; abort wins over go and over a completing frame.
   always_comb begin
      w_next_state = r_state;
      if (abort) begin
         w_next_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (go) begin
                  w_next_state = ST_ARM;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end
            ST_ARM: begin
               w_next_state = ST_SEND;
            end
            ST_SEND: begin
               if (w_last_xfer) begin
                  w_next_state = ST_TAIL;
               end else begin
                  w_next_state = ST_SEND;
               end
            end
            ST_TAIL: begin
               if (r_tail_cnt == TAIL_LAST) begin
                  w_next_state = ST_IDLE;
               end else begin
                  w_next_state = ST_TAIL;
               end
            end
            default: begin
               w_next_state = ST_IDLE;
            end
         endcase
      end
   end

   // Output decode, computed one cycle ahead so the control outputs come from flops.
   always_comb begin
      w_start_d      = stage_enabled(w_next_state);
      w_busy_d       = (w_next_state != ST_IDLE);
      w_frame_done_d = w_last_xfer && !abort;
   end

   // Output pixel register: holds its beat until accepted, reloads straight from the FIFO head.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= 1'b0;
         r_pix   <= 8'd0;
      end else if (abort) begin
         r_valid <= 1'b0;
      end else if (w_pop) begin
         r_valid <= 1'b1;
         r_pix   <= w_fifo_head;
      end else if (w_xfer) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   // Raster position of the next pixel to be transferred.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_col <= '0;
         r_row <= '0;
      end else if (abort) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_xfer) begin
         if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // Tail hold counter and sticky overflow flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_tail_cnt <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_tail_cnt <= (r_state == ST_TAIL) ? r_tail_cnt + TW'(1) : '0;
         r_overflow <= r_overflow | w_fifo_drop;
      end
   end

   assign wr_full    = w_fifo_full;
   assign overflow   = r_overflow;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign pixel_out  = r_pix;
   assign VALID_OUT  = r_valid;
   assign start      = r_start;
   assign col        = r_col;
   assign row        = r_row;

endmodule

// File: doc/pixel_stream_tx.md
PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
REQ-001 SHALL have parameters IMG_WIDTH, default 32, pixels per line; IMG_HEIGHT, default 32, lines per frame; FIFO_DEPTH, default 64, power of two, pixel FIFO entries; TAIL_CYCLES, default 4, start hold after last pixel.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rstn  input  1  asynchronous active-low reset.
REQ-003 SHALL have the host write side: wr_en  input  1  push strobe; wr_data  input  8  pixel to push; wr_full  output  1  FIFO full; overflow  output  1  sticky, write attempted while full.
REQ-004 SHALL have the control side: go  input  1  one-cycle frame start request; abort  input  1  synchronous cancel; busy  output  1  high in any state except IDLE; frame_done  output  1  one-cycle pulse.
REQ-005 SHALL have the stream side toward the processing stage: pixel_out  output  8  pixel; VALID_OUT  output  1  pixel valid; READY_IN  input  1  downstream ready; start  output  1  processing-stage enable.
REQ-006 SHALL expose col  output  $clog2(IMG_WIDTH)  and row  output  $clog2(IMG_HEIGHT): position of the next pixel to be transferred.

Function
REQ-007 SHALL implement states IDLE, ARM, SEND, TAIL.
REQ-008 IDLE->ARM on go=1; go in any other state SHALL be ignored.
REQ-009 ARM SHALL last exactly one cycle with start=1 and VALID_OUT=0, then enter SEND, so the downstream stage is enabled before the first beat.
REQ-010 start SHALL be 1 in ARM, SEND and TAIL and 0 in IDLE.
REQ-011 A beat SHALL be transferred on every clock edge where VALID_OUT=1 and READY_IN=1; pixel_out SHALL be stable while VALID_OUT=1 and READY_IN=0.
REQ-012 In SEND, the registered output stage SHALL load from the FIFO head when FIFO non-empty and (VALID_OUT=0 or READY_IN=1), giving 1-cycle latency FIFO-head -> VALID_OUT and sustaining one beat per cycle.
REQ-013 FIFO empty in SEND SHALL deassert VALID_OUT after the current beat completes; no bubble data emitted.
REQ-014 col SHALL increment per transferred beat, wrap IMG_WIDTH-1 -> 0 and increment row; row SHALL wrap IMG_HEIGHT-1 -> 0.
REQ-015 Transfer of beat (col=IMG_WIDTH-1,row=IMG_HEIGHT-1) SHALL enter TAIL, pulse frame_done on the next cycle, and stop further FIFO reads for this frame.
REQ-016 TAIL SHALL count TAIL_CYCLES cycles with VALID_OUT=0, then return to IDLE with col=row=0.
REQ-017 FIFO writes SHALL be accepted in every state; push with wr_full=1 SHALL be dropped and set overflow until reset.
REQ-018 Simultaneous push and pop SHALL keep occupancy unchanged, including at full (push accepted because a pop occurs) and at empty (pushed word not popped same cycle).
REQ-019 abort=1 SHALL, from any state, return to IDLE next cycle with VALID_OUT=0, start=0, col=row=0, FIFO flushed; abort has priority over go and over a simultaneous transfer (beat counts as transferred downstream but counters reset).
REQ-020 Pixels remaining in the FIFO after frame end SHALL be kept for the next frame.

Reset
REQ-021 rstn=0 SHALL asynchronously force IDLE, pixel_out=0, VALID_OUT=0, start=0, busy=0, frame_done=0, overflow=0, col=row=0, FIFO empty (wr_full=0).
REQ-022 Reset deassertion mid-frame SHALL resume nothing; the block waits for go.

Structure
REQ-023 State encoding and default IMG_WIDTH/IMG_HEIGHT SHALL live in a shared package used by this block and the processing stage.
REQ-024 The FIFO SHALL be a sub-module pixel_fifo (synchronous, first-word-fall-through head, full/empty flags, flush input).

Verification
REQ-025 Push 1024 pixels 0..255 repeating, go, READY_IN=1 -> start rises 1 cycle before first VALID_OUT, 1024 beats in order on consecutive cycles, frame_done one cycle after beat 1024, start low after TAIL_CYCLES.
REQ-026 Same frame, READY_IN toggling 1/0 randomly -> pixel_out held during stalls, sequence intact, col/row wrap at 31/31.
REQ-027 Push 64 while idle, then 1 more -> wr_full=1, overflow=1, 65th pixel never emitted.
REQ-028 Push 10, go, feed rest slowly -> VALID_OUT drops while FIFO empty, resumes without duplicates.
REQ-029 abort at beat 100 -> next cycle IDLE, VALID_OUT=0, start=0, FIFO empty; subsequent go with new data starts at col=row=0.
REQ-030 rstn pulsed low mid-SEND between edges -> outputs zero immediately, FIFO empty after release.
